mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Memory stage of the pipelined Y86-64 core, fused with the W pipeline register. It consumes the M-register fields (cnd, stat, icode, valE, valA, dstE, dstM) and performs the data-memory access against an internal byte-addressable, little-endian data memory. Access latency is configurable; while an access is in flight the block raises m_stall, and pipeline control holds the M register stable for that time. Results are registered into the W_* outputs that feed writeback.

Parameters:
- MEM_BYTES, 1024, data memory size in bytes.
- MEM_LAT, 1, cycles per memory access; legal range 1..15.
- SAOK / SHLT / SADR / SINS / SBUB, 1 / 2 / 3 / 4 / 8, stat codes.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- M_cnd  in  1  condition flag from the M register.
- M_stat  in  4  stat from the M register.
- M_icode  in  4  instruction code.
- M_valE  in  64  ALU result / effective address.
- M_valA  in  64  store data or stack pointer.
- M_dstE  in  4  E destination register (4'hF = none).
- M_dstM  in  4  M destination register.
- m_stall  out  1  combinational; asks control to hold M and bubble W.
- m_halted  out  1  a terminating stat has reached W.
- W_stat, W_icode, W_dstE, W_dstM  out  4 each  W register fields.
- W_valE, W_valM  out  64 each  W register data fields.
- W_cnd  out  1  W register condition flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low. At a posedge with rst_n=0:
  - W_stat=8, W_icode=1, W_dstE=W_dstM=4'hF, W_valE=W_valM=0, W_cnd=0.
  - Wait counter cnt=0, m_halted=0.
  - Memory contents are not cleared.
  - Reset during a multi-cycle access abandons it: no write occurs.
- Op classes:
  - Reads: mrmovq (5) at M_valE; popq (B) and ret (9) at M_valA.
  - Writes of M_valA: rmmovq (4), pushq (A) and call (8), all at M_valE.
  - All other icodes are non-memory ops.
- Access width: 8 bytes, little-endian. Out of range when addr > MEM_BYTES-8, using an unsigned 64-bit compare with no wrap.
- Gating: an op is live when M_stat==SAOK and m_halted==0.
- Non-memory op, non-live op, or out-of-range memory op: completes in one cycle. W captures all M fields at the next posedge, with:
  - W_valM = 0;
  - W_stat = SADR if out of range, otherwise M_stat;
  - no memory write.
- Live in-range memory op, FSM states:
  - IDLE (cnt==0). An op arrives.
  - WAIT (0 < cnt < MEM_LAT-1).
  - m_stall = mem_op && in_range && live && (cnt != MEM_LAT-1).
  - Each posedge with m_stall=1: cnt += 1, and W loads a bubble (stat 8, icode 1, dstE/dstM F, valE/valM 0, cnd 0).
  - Posedge with m_stall=0 (completion):
    - writes commit all 8 bytes;
    - reads load W_valM with the little-endian word;
    - W captures the M fields;
    - cnt returns to 0 (IDLE).
  - With MEM_LAT=1, m_stall is never asserted.
- Read-after-write: a read issued the cycle after a write completes sees the new data.
- Halt: when W captures a stat in {SHLT, SADR, SINS}, m_halted=1 at that edge. Afterwards:
  - all ops are non-live, so no memory writes occur;
  - W still captures fields;
  - m_halted stays set until reset.
- Bubble input (M_stat=8, M_icode=1) passes to W in one cycle unchanged.
- M inputs must be stable while m_stall=1. If they change mid-wait, the op present at completion is the one executed; cnt is not restarted.

Test Plan:
- Reset: rst_n=0 for 1 cycle → W_stat=8, W_icode=1, W_dstE=F, m_stall=0, m_halted=0.
- MEM_LAT=1:
  - rmmovq, valE=0x10, valA=0x1122334455667788;
  - then mrmovq valE=0x10, dstM=3 → W_valM=0x1122334455667788 one cycle after the load;
  - byte 0x10 holds 0x88.
- MEM_LAT=3, mrmovq valE=0x20 → m_stall high for 2 cycles, W bubbles twice, W_icode=5 with data on the 3rd edge.
- Out-of-range: mrmovq valE=MEM_BYTES-7, then rmmovq valE=0xFFFFFFFFFFFFFFF8 → each completes in 1 cycle with W_stat=3, m_halted=1, no memory change, no stall.
- Halt gating: halt op (W_stat=2), then rmmovq to 0x40 → 0x40 unchanged, m_halted stays 1.
- Reset mid-wait: MEM_LAT=4, rmmovq to 0x30, rst_n low on the 2nd stall cycle → 0x30 unchanged, cnt=0, m_stall=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Y86-64 memory stage fused with the W pipeline register.
// Owns a byte-addressable little-endian data memory with configurable access latency.

package mem_wb_stage_pkg;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic        cnd;
  } w_reg_t;

endpackage

module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned MEM_LAT   = 1,
  parameter logic [3:0]  SAOK      = 4'd1,
  parameter logic [3:0]  SHLT      = 4'd2,
  parameter logic [3:0]  SADR      = 4'd3,
  parameter logic [3:0]  SINS      = 4'd4,
  parameter logic [3:0]  SBUB      = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_cnd,
  input  logic [3:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  output logic        m_stall,
  output logic        m_halted,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic        W_cnd
);

  localparam int unsigned AW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned CW       = 4;
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);
  localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LAT - 1);

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam w_reg_t W_BUBBLE = '{stat: SBUB, icode: 4'h1, dst_e: 4'hF, dst_m: 4'hF,
                                  val_e: 64'd0, val_m: 64'd0, cnd: 1'b0};

  logic [7:0]    mem [MEM_BYTES];
  logic [CW-1:0] cnt_q, cnt_d;
  w_reg_t        w_q, w_d;
  logic          halted_q, halted_d;

  logic          is_rd, is_wr, mem_op, in_range, live, access, wr_en;
  logic [63:0]   addr, rd_word;
  logic [AW-1:0] base;
  logic [3:0]    stat_nxt;

  // Decode the M-register op, resolve its address and read the addressed word.
  always_comb begin
    is_rd    = (M_icode == I_MRMOVQ) || (M_icode == I_RET) || (M_icode == I_POPQ);
    is_wr    = (M_icode == I_RMMOVQ) || (M_icode == I_PUSHQ) || (M_icode == I_CALL);
    mem_op   = is_rd || is_wr;
    addr     = ((M_icode == I_RET) || (M_icode == I_POPQ)) ? M_valA : M_valE;
    in_range = (addr <= MAX_ADDR);
    live     = (M_stat == SAOK) && !halted_q;
    access   = mem_op && in_range && live;
    base     = in_range ? addr[AW-1:0] : '0;
    rd_word  = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[base + AW'(i)];
    end
    m_stall  = access && (cnt_q != LAST_CNT);
  end

  // Latency counter doubles as the IDLE/WAIT state; stall cycles bubble W.
  always_comb begin
    cnt_d    = cnt_q;
    w_d      = w_q;
    halted_d = halted_q;
    wr_en    = 1'b0;
    stat_nxt = (mem_op && !in_range) ? SADR : M_stat;
    if (m_stall) begin
      cnt_d = cnt_q + CW'(1);
      w_d   = W_BUBBLE;
    end else begin
      cnt_d = '0;
      w_d   = '{stat: stat_nxt, icode: M_icode, dst_e: M_dstE, dst_m: M_dstM,
                val_e: M_valE, val_m: (access && is_rd) ? rd_word : 64'd0, cnd: M_cnd};
      wr_en = access && is_wr;
      if ((stat_nxt == SHLT) || (stat_nxt == SADR) || (stat_nxt == SINS)) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      w_q      <= W_BUBBLE;
      halted_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      halted_q <= halted_d;
    end
  end

  // Memory is never cleared; a reset edge suppresses a completing store.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= M_valA[8*i +: 8];
      end
    end
  end

  assign m_halted = halted_q;
  assign W_stat   = w_q.stat;
  assign W_icode  = w_q.icode;
  assign W_dstE   = w_q.dst_e;
  assign W_dstM   = w_q.dst_m;
  assign W_valE   = w_q.val_e;
  assign W_valM   = w_q.val_m;
  assign W_cnd    = w_q.cnd;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: three instances (latency 1, 3, 4) share the M inputs;
// idle instances are held in reset. Directed cases plus a randomized model check.

module tb_mem_wb_stage;

  localparam int unsigned MEM_BYTES = 1024;
  localparam logic [3:0] SAOK = 4'd1, SHLT = 4'd2, SADR = 4'd3, SINS = 4'd4, SBUB = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        m_cnd;
  logic [3:0]  m_stat, m_icode, m_dst_e, m_dst_m;
  logic [63:0] m_val_e, m_val_a;

  logic        stall [3];
  logic        halted [3];
  logic [3:0]  w_stat [3];
  logic [3:0]  w_icode [3];
  logic [3:0]  w_dst_e [3];
  logic [3:0]  w_dst_m [3];
  logic [63:0] w_val_e [3];
  logic [63:0] w_val_m [3];
  logic        w_cnd [3];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mdl_mem [MEM_BYTES];
  bit         mdl_halted = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_wb_stage #(
      .MEM_BYTES(MEM_BYTES),
      .MEM_LAT  ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n[g]),
      .M_cnd   (m_cnd),
      .M_stat  (m_stat),
      .M_icode (m_icode),
      .M_valE  (m_val_e),
      .M_valA  (m_val_a),
      .M_dstE  (m_dst_e),
      .M_dstM  (m_dst_m),
      .m_stall (stall[g]),
      .m_halted(halted[g]),
      .W_stat  (w_stat[g]),
      .W_icode (w_icode[g]),
      .W_dstE  (w_dst_e[g]),
      .W_dstM  (w_dst_m[g]),
      .W_valE  (w_val_e[g]),
      .W_valM  (w_val_m[g]),
      .W_cnd   (w_cnd[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] stat, input logic [63:0] ve,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                       input logic c);
    m_icode = icode; m_stat = stat; m_val_e = ve; m_val_a = va;
    m_dst_e = de; m_dst_m = dm; m_cnd = c;
    #1;
  endtask

  task automatic pulse_reset(input int k);
    rst_n[k] = 1'b0;
    tick();
    rst_n[k] = 1'b1;
  endtask

  // Holds the driven op until it completes; W must show a bubble after every stall edge.
  task automatic run_op(input int k, output int stalls);
    stalls = 0;
    while (stall[k] && stalls < 20) begin
      tick();
      stalls++;
      check("bubble_stat", 64'(w_stat[k]), 64'(SBUB));
      check("bubble_icode", 64'(w_icode[k]), 64'h1);
    end
    tick();
  endtask

  // Reference: applies the op rules directly to a byte array, then compares W on instance 1.
  task automatic exec_op(input logic [3:0] icode, input logic [3:0] stat, input logic [63:0] ve,
                         input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                         input logic c);
    bit rd, wr, mem, inr, live;
    logic [63:0] addr, valm;
    logic [3:0] est;
    int st;
    rd   = icode inside {4'h5, 4'h9, 4'hB};
    wr   = icode inside {4'h4, 4'h8, 4'hA};
    mem  = rd || wr;
    addr = (icode inside {4'h9, 4'hB}) ? va : ve;
    inr  = addr <= 64'(MEM_BYTES - 8);
    live = (stat == SAOK) && !mdl_halted;
    valm = '0;
    if (mem && inr && live && rd)
      for (int b = 0; b < 8; b++) valm[8*b +: 8] = mdl_mem[int'(addr) + b];
    est = (mem && !inr) ? SADR : stat;
    drive(icode, stat, ve, va, de, dm, c);
    run_op(1, st);
    check("rnd_latency", 64'(st), (mem && inr && live) ? 64'd2 : 64'd0);
    check("rnd_stat", 64'(w_stat[1]), 64'(est));
    check("rnd_icode", 64'(w_icode[1]), 64'(icode));
    check("rnd_valE", w_val_e[1], ve);
    check("rnd_valM", w_val_m[1], valm);
    check("rnd_dstE", 64'(w_dst_e[1]), 64'(de));
    check("rnd_dstM", 64'(w_dst_m[1]), 64'(dm));
    check("rnd_cnd", 64'(w_cnd[1]), 64'(c));
    if (mem && inr && live && wr)
      for (int b = 0; b < 8; b++) mdl_mem[int'(addr) + b] = va[8*b +: 8];
    if (est inside {SHLT, SADR, SINS}) mdl_halted = 1'b1;
    check("rnd_halted", 64'(halted[1]), 64'(mdl_halted));
    if (mdl_halted) begin
      pulse_reset(1);
      mdl_halted = 1'b0;
    end
  endtask

  initial begin
    int st;
    logic [63:0] d1, d2;
    logic [3:0] icode, stat;
    logic [63:0] addr, ve, va;
    int r;

    for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
    drive(4'h1, SBUB, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0);
    tick();
    check("rst_stat", 64'(w_stat[0]), 64'd8);
    check("rst_icode", 64'(w_icode[0]), 64'd1);
    check("rst_dstE", 64'(w_dst_e[0]), 64'hF);
    check("rst_dstM", 64'(w_dst_m[0]), 64'hF);
    check("rst_valM", w_val_m[0], 64'd0);
    check("rst_stall", 64'(stall[0]), 64'd0);
    check("rst_halted", 64'(halted[0]), 64'd0);

    // Latency 1: store then load back, little-endian byte order.
    rst_n[0] = 1'b1;
    drive(4'h4, SAOK, 64'h10, 64'h1122334455667788, 4'hF, 4'hF, 1'b0);
    run_op(0, st);
    check("l1_st_latency", 64'(st), 64'd0);
    check("l1_st_icode", 64'(w_icode[0]), 64'h4);
    check("l1_st_valM", w_val_m[0], 64'd0);
    drive(4'h5, SAOK, 64'h10, 64'd0, 4'hF, 4'h3, 1'b0);
    run_op(0, st);
    check("l1_ld_valM", w_val_m[0], 64'h1122334455667788);
    check("l1_ld_dstM", 64'(w_dst_m[0]), 64'h3);
    check("l1_byte10", 64'(g_dut[0].u_dut.mem[16]), 64'h88);

    // Out-of-range accesses complete at once with SADR and halt.
    drive(4'h5, SAOK, 64'(MEM_BYTES - 7), 64'd0, 4'hF, 4'h2, 1'b0);
    run_op(0, st);
    check("oor_rd_latency", 64'(st), 64'd0);
    check("oor_rd_stat", 64'(w_stat[0]), 64'(SADR));
    check("oor_rd_halted", 64'(halted[0]), 64'd1);
    drive(4'h4, SAOK, 64'hFFFFFFFFFFFFFFF8, 64'hDEAD, 4'hF, 4'hF, 1'b0);
    run_op(0, st);
    check("oor_wr_latency", 64'(st), 64'd0);
    check("oor_wr_stat", 64'(w_stat[0]), 64'(SADR));
    check("oor_wr_halted", 64'(halted[0]), 64'd1);

    // Halt gating: stores after a halt must not reach memory.
    pulse_reset(0);
    check("rst_clears_halt", 64'(halted[0]), 64'd0);
    drive(4'h4, SAOK, 64'h40, 64'hA0A1A2A3A4A5A6A7, 4'hF, 4'hF, 1'b0);
    run_op(0, st);
    drive(4'h0, SHLT, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0);
    run_op(0, st);
    check("halt_stat", 64'(w_stat[0]), 64'(SHLT));
    check("halt_set", 64'(halted[0]), 64'd1);
    drive(4'h4, SAOK, 64'h40, 64'hB0B1B2B3B4B5B6B7, 4'hF, 4'hF, 1'b1);
    run_op(0, st);
    check("halted_wr_icode", 64'(w_icode[0]), 64'h4);
    check("halted_wr_cnd", 64'(w_cnd[0]), 64'h1);
    check("halted_sticky", 64'(halted[0]), 64'd1);
    check("halted_byte40", 64'(g_dut[0].u_dut.mem[64]), 64'hA7);
    pulse_reset(0);
    drive(4'h5, SAOK, 64'h40, 64'd0, 4'hF, 4'h1, 1'b0);
    run_op(0, st);
    check("halted_word40", w_val_m[0], 64'hA0A1A2A3A4A5A6A7);
    rst_n[0] = 1'b0;

    // Latency 3: two stall cycles with bubbles, data on the third edge.
    rst_n[1] = 1'b1;
    drive(4'h4, SAOK, 64'h20, 64'h0123456789ABCDEF, 4'hF, 4'hF, 1'b0);
    check("l3_stall_now", 64'(stall[1]), 64'd1);
    run_op(1, st);
    check("l3_st_latency", 64'(st), 64'd2);
    drive(4'h5, SAOK, 64'h20, 64'd0, 4'hF, 4'h5, 1'b0);
    run_op(1, st);
    check("l3_ld_latency", 64'(st), 64'd2);
    check("l3_ld_icode", 64'(w_icode[1]), 64'h5);
    check("l3_ld_valM", w_val_m[1], 64'h0123456789ABCDEF);
    // popq reads at valA; pushq writes at valE.
    drive(4'hA, SAOK, 64'h28, 64'h5555AAAA5555AAAA, 4'h4, 4'hF, 1'b0);
    run_op(1, st);
    drive(4'hB, SAOK, 64'h30, 64'h28, 4'h4, 4'h7, 1'b0);
    run_op(1, st);
    check("l3_pop_valM", w_val_m[1], 64'h5555AAAA5555AAAA);
    check("l3_pop_valE", w_val_e[1], 64'h30);

    // Latency 4: reset mid-wait and reset on the completion edge both drop the store.
    rst_n[1] = 1'b0;
    rst_n[2] = 1'b1;
    d1 = 64'h3030303030303031;
    d2 = 64'h3838383838383839;
    drive(4'h4, SAOK, 64'h30, d1, 4'hF, 4'hF, 1'b0);
    run_op(2, st);
    check("l4_latency", 64'(st), 64'd3);
    drive(4'h4, SAOK, 64'h38, d2, 4'hF, 4'hF, 1'b0);
    run_op(2, st);
    drive(4'h4, SAOK, 64'h30, 64'hEEEEEEEEEEEEEEEE, 4'hF, 4'hF, 1'b0);
    tick();
    check("l4_stall2", 64'(stall[2]), 64'd1);
    pulse_reset(2);
    drive(4'h1, SBUB, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0);
    check("l4_rst_stall", 64'(stall[2]), 64'd0);
    check("l4_rst_stat", 64'(w_stat[2]), 64'(SBUB));
    drive(4'h4, SAOK, 64'h38, 64'hFFFFFFFFFFFFFFFF, 4'hF, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("l4_final_nostall", 64'(stall[2]), 64'd0);
    pulse_reset(2);
    drive(4'h5, SAOK, 64'h30, 64'd0, 4'hF, 4'h1, 1'b0);
    run_op(2, st);
    check("l4_word30", w_val_m[2], d1);
    check("l4_lat_after_rst", 64'(st), 64'd3);
    drive(4'h5, SAOK, 64'h38, 64'd0, 4'hF, 4'h1, 1'b0);
    run_op(2, st);
    check("l4_word38", w_val_m[2], d2);
    rst_n[2] = 1'b0;

    // Randomized ops on latency-3 instance against the byte-array model.
    pulse_reset(1);
    mdl_halted = 1'b0;
    for (int w = 0; w < 16; w++)
      exec_op(4'h4, SAOK, 64'(32'h100 + 8 * w), {$urandom, $urandom}, 4'hF, 4'hF, 1'b0);
    for (int n = 0; n < 300; n++) begin
      icode = 4'($urandom_range(0, 11));
      r = int'($urandom_range(0, 19));
      stat = (r < 17) ? SAOK : ((r == 17) ? SBUB : ((r == 18) ? SINS : SHLT));
      if ($urandom_range(0, 15) == 0)
        addr = ($urandom_range(0, 1) == 1) ? 64'(MEM_BYTES - 7 + $urandom_range(0, 50))
                                          : {32'hFFFFFFFF, $urandom};
      else
        addr = 64'(32'h100 + $urandom_range(0, 32'h78));
      if (icode inside {4'h9, 4'hB}) begin
        ve = {$urandom, $urandom};
        va = addr;
      end else begin
        ve = addr;
        va = {$urandom, $urandom};
      end
      exec_op(icode, stat, ve, va, 4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
